// File: rtl/psram_bridge_pkg.sv
`timescale 1ns/1ps
// psram_bridge_pkg
//   Shared types and helpers for the APB3-to-Wishbone PSRAM bridge:
//   the FSM state encoding, the byte-strobe legality check, the read data
//   returned on failed or no-op reads, and the write-lane screening decode.
package psram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Read data handed back when no PSRAM access took place.
    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Reads always fetch the whole word.
    localparam logic [3:0] SEL_READ = 4'b1111;

    // Byte-strobe patterns the PSRAM controller can serve: single bytes,
    // aligned halfwords and the full word.
    function automatic logic strb_legal(input logic [3:0] strb);
        logic ok;
        ok = 1'b0;
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Mask selecting the forwarded PSRAM byte-address bits.
    function automatic logic [31:0] addr_mask(input int addr_w);
        logic [63:0] m;
        m = (64'h1 << addr_w) - 64'h1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/psram_apb_wb_bridge.sv
`timescale 1ns/1ps
// psram_apb_wb_bridge
//   APB3 slave to Wishbone classic master bridge sitting directly in front of
//   the PSRAM Wishbone controller. One APB transfer becomes at most one WB
//   cycle; PREADY is held low until the WB ACK arrives. Accesses outside the
//   APB window and writes with strobe patterns the controller cannot serve are
//   answered locally with PSLVERR and never reach the WB bus. A write with no
//   strobes set is answered locally as a successful no-op.
//
//   Optional feature macro: PSRAM_BRIDGE_TIMEOUT_EN
//     defined   - a WB cycle left unacknowledged for TIMEOUT_CYC cycles is
//                 abandoned and the APB transfer ends with PSLVERR.
//     undefined - the bridge waits for ack_i indefinitely.
module psram_apb_wb_bridge
    import psram_bridge_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // APB3 slave
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    // Wishbone classic master
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i
);

    localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_W);

    state_t state;

    // Setup-phase decode of the incoming APB request.
    logic setup;
    logic in_window;
    logic screen_err;
    logic write_noop;
    logic to_expired;

    assign setup      = psel & ~penable;
    assign in_window  = (paddr & ~ADDR_MASK) == (BASE_ADDR & ~ADDR_MASK);
    // An out-of-window access is an error even if it is an empty write.
    assign screen_err = ~in_window
                      | (pwrite & (pstrb != 4'b0000) & ~strb_legal(pstrb));
    assign write_noop = in_window & pwrite & (pstrb == 4'b0000);

    // Classic single-beat master: the strobe tracks the cycle.
    assign stb_o = cyc_o;

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] to_cnt;

    // Cycle counter for the current WB request; held at zero outside REQ so
    // every request starts counting from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state != REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Expiry on the last permitted REQ cycle, so cyc_o is high for exactly
    // TIMEOUT_CYC cycles before it is dropped.
    assign to_expired = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign to_expired = 1'b0;
`endif

    // Transfer FSM with registered APB response and WB request outputs.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and the block order cannot matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            prdata  <= ERR_RDATA;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
            sel_o   <= '0;
            we_o    <= 1'b0;
            cyc_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        // Request registers double as the WB outputs and
                        // stay frozen until the next setup phase.
                        we_o   <= pwrite;
                        dat_o  <= pwdata;
                        sel_o  <= pwrite ? pstrb : SEL_READ;
                        adr_o  <= pwrite ? (paddr & ADDR_MASK)
                                         : (paddr & ADDR_MASK & ~32'h3);
                        prdata <= ERR_RDATA;
                        if (screen_err) begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            state   <= RESP;
                        end else if (write_noop) begin
                            pready  <= 1'b1;
                            pslverr <= 1'b0;
                            state   <= RESP;
                        end else begin
                            cyc_o <= 1'b1;
                            state <= REQ;
                        end
                    end
                end

                REQ: begin
                    // ack_i takes priority over an expiry in the same cycle.
                    if (ack_i) begin
                        cyc_o   <= 1'b0;
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                        if (!we_o) begin
                            prdata <= dat_i;
                        end
                        state <= RESP;
                    end else if (to_expired) begin
                        cyc_o   <= 1'b0;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= ERR_RDATA;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    // One-cycle APB completion; ack_i seen here is stale.
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    cyc_o   <= 1'b0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_apb_wb_bridge.sv
`timescale 1ns/1ps
// tb_psram_apb_wb_bridge
//   Self-checking bench for psram_apb_wb_bridge. An APB master task drives one
//   transfer while acting as the Wishbone slave; expected results come from a
//   transfer-level model of the bridge's screening rules and latency.
//   Honours PSRAM_BRIDGE_TIMEOUT_EN the same way the design does.
module tb_psram_apb_wb_bridge;

    localparam int TO_CYC = 8;
    localparam int BUDGET = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i = 1'b0;

    int total = 0;
    int bad   = 0;

    // What one APB transfer looked like from the outside.
    typedef struct {
        int          k;             // cycles after setup until pready, 0 = never
        logic [31:0] rdata;
        logic        err;
        int          wb_cycles;     // number of cyc_o rising edges
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        logic        unstable;      // WB request changed or stb_o != cyc_o mid-cycle
        logic        cyc_at_ready;
        logic        pready_before; // pready when this setup phase was driven
    } obs_t;

    psram_apb_wb_bridge #(
        .ADDR_W     (24),
        .BASE_ADDR  (32'h8000_0000),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .paddr  (paddr),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .sel_o  (sel_o),
        .we_o   (we_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .ack_i  (ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (transfer level) ----------------
    // Decides whether a WB cycle is issued and which error is returned.
    task automatic model(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                         output logic exp_wb, output logic exp_err);
        logic legal;
        legal = strb inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        if (addr[31:24] != 8'h80) begin
            exp_wb = 0; exp_err = 1;
        end else if (wr && strb == 4'h0) begin
            exp_wb = 0; exp_err = 0;
        end else if (wr && !legal) begin
            exp_wb = 0; exp_err = 1;
        end else begin
            exp_wb = 1; exp_err = 0;
        end
    endtask

    // ---------------- stimulus drivers ----------------
    // One APB transfer; acts as WB slave acking after ack_delay cycles of cyc_o
    // (ack_delay < 0 never acks). Leaves psel/penable high on return so a
    // following call is a back-to-back transfer.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int ack_delay,
                        input logic [31:0] wb_rdata, output obs_t o);
        int   n;
        logic prev_cyc;
        bit   done;
        o = '{default: 0};
        @(negedge clk_i);
        o.pready_before = pready;
        psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
        ack_i = 0; dat_i = ~wb_rdata;
        n = 0; prev_cyc = 0; done = 0;
        for (int k = 1; k <= BUDGET && !done; k++) begin
            @(negedge clk_i);
            penable = 1;
            ack_i = 0;
            dat_i = ~wb_rdata;
            if (stb_o !== cyc_o) o.unstable = 1;
            if (cyc_o === 1'b1) begin
                if (!prev_cyc) begin
                    o.wb_cycles++;
                    o.adr = adr_o; o.sel = sel_o; o.we = we_o; o.dat = dat_o;
                end else if (adr_o !== o.adr || sel_o !== o.sel || we_o !== o.we || dat_o !== o.dat) begin
                    o.unstable = 1;
                end
                n++;
                if (ack_delay >= 0 && n == ack_delay + 1) begin
                    ack_i = 1;
                    dat_i = wb_rdata;
                end
            end
            prev_cyc = cyc_o;
            if (pready === 1'b1) begin
                o.k = k; o.rdata = prdata; o.err = pslverr; o.cyc_at_ready = cyc_o;
                done = 1;
            end
        end
    endtask

    task automatic bus_idle();
        @(negedge clk_i);
        psel = 0; penable = 0; ack_i = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        total++;
        if ({prdata, pready, pslverr} !== 34'h0) begin
            bad++; $display("FAIL reset_apb: got %h want 0", {prdata, pready, pslverr});
        end
        total++;
        if ({adr_o, dat_o, sel_o, we_o, cyc_o, stb_o} !== 71'h0) begin
            bad++; $display("FAIL reset_wb: got %h want 0", {adr_o, dat_o, sel_o, we_o, cyc_o, stb_o});
        end
        rst_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_read_basic();
        obs_t o;
        xfer(32'h8000_0010, 0, 32'h1234_5678, 4'h0, 4, 32'hCAFE_F00D, o);
        bus_idle();
        total++; if (o.adr !== 32'h10) begin bad++; $display("FAIL rd_adr: got %h want 10", o.adr); end
        total++; if (o.sel !== 4'hF) begin bad++; $display("FAIL rd_sel: got %h want f", o.sel); end
        total++; if (o.we !== 1'b0) begin bad++; $display("FAIL rd_we: got %b want 0", o.we); end
        total++; if (o.rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_data: got %h want cafef00d", o.rdata); end
        total++; if (o.err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", o.err); end
        total++; if (o.k != 6) begin bad++; $display("FAIL rd_latency: got %0d want 6", o.k); end
        total++; if (o.cyc_at_ready !== 1'b0) begin bad++; $display("FAIL rd_cyc_drop: got %b want 0", o.cyc_at_ready); end
    endtask

    task automatic test_write_basic();
        obs_t o;
        xfer(32'h8000_0006, 1, 32'hAABB_0000, 4'b1100, 1, 32'h0, o);
        bus_idle();
        total++; if (o.we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", o.we); end
        total++; if (o.sel !== 4'b1100) begin bad++; $display("FAIL wr_sel: got %b want 1100", o.sel); end
        total++; if (o.dat !== 32'hAABB_0000) begin bad++; $display("FAIL wr_dat: got %h want aabb0000", o.dat); end
        total++; if (o.adr !== 32'h6) begin bad++; $display("FAIL wr_adr: got %h want 6", o.adr); end
        total++; if (o.wb_cycles != 1) begin bad++; $display("FAIL wr_cycles: got %0d want 1", o.wb_cycles); end
        total++; if (o.unstable !== 1'b0) begin bad++; $display("FAIL wr_stable: got %b want 0", o.unstable); end
        total++; if ({o.k, o.err} !== {32'd3, 1'b0}) begin bad++; $display("FAIL wr_resp: got k=%0d err=%b want k=3 err=0", o.k, o.err); end
    endtask

    task automatic test_strobe_screen();
        obs_t o;
        xfer(32'h8000_0020, 1, 32'h5555_AAAA, 4'b0101, 2, 32'h0, o);
        total++; if ({o.wb_cycles, o.err, o.k} !== {32'd0, 1'b1, 32'd1}) begin
            bad++; $display("FAIL strb_illegal: got cyc=%0d err=%b k=%0d want 0 1 1", o.wb_cycles, o.err, o.k); end
        xfer(32'h8000_0020, 1, 32'h5555_AAAA, 4'b0000, 2, 32'h0, o);
        total++; if ({o.wb_cycles, o.err, o.k} !== {32'd0, 1'b0, 32'd1}) begin
            bad++; $display("FAIL strb_noop: got cyc=%0d err=%b k=%0d want 0 0 1", o.wb_cycles, o.err, o.k); end
        bus_idle();
    endtask

    task automatic test_out_of_window();
        obs_t o;
        xfer(32'h9000_0000, 0, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, o);
        bus_idle();
        total++; if ({o.wb_cycles, o.err, o.k} !== {32'd0, 1'b1, 32'd1}) begin
            bad++; $display("FAIL oow_resp: got cyc=%0d err=%b k=%0d want 0 1 1", o.wb_cycles, o.err, o.k); end
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL oow_rdata: got %h want 0", o.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
        xfer(32'h8000_0100, 0, 32'h0, 4'hF, -1, 32'h1111_2222, o);
        bus_idle();
        total++; if ({o.k, o.err, o.cyc_at_ready} !== {32'(TO_CYC + 1), 1'b1, 1'b0}) begin
            bad++; $display("FAIL to_expire: got k=%0d err=%b cyc=%b want k=%0d err=1 cyc=0", o.k, o.err, o.cyc_at_ready, TO_CYC + 1); end
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", o.rdata); end
        // ack on the expiry cycle still completes normally
        xfer(32'h8000_0104, 0, 32'h0, 4'hF, TO_CYC - 1, 32'h3333_4444, o);
        bus_idle();
        total++; if ({o.k, o.err, o.rdata} !== {32'(TO_CYC + 1), 1'b0, 32'h3333_4444}) begin
            bad++; $display("FAIL to_ack_wins: got k=%0d err=%b rd=%h want k=%0d err=0 rd=33334444", o.k, o.err, o.rdata, TO_CYC + 1); end
`else
        // without the timeout the bridge keeps waiting well past TO_CYC
        xfer(32'h8000_0100, 0, 32'h0, 4'hF, 40, 32'h1111_2222, o);
        bus_idle();
        total++; if ({o.k, o.err, o.rdata} !== {32'd42, 1'b0, 32'h1111_2222}) begin
            bad++; $display("FAIL no_timeout: got k=%0d err=%b rd=%h want k=42 err=0 rd=11112222", o.k, o.err, o.rdata); end
`endif
    endtask

    task automatic test_reset_in_req();
        obs_t o;
        @(negedge clk_i);
        psel = 1; penable = 0; paddr = 32'h8000_0040; pwrite = 0; pstrb = 4'hF;
        @(negedge clk_i);
        penable = 1;
        @(negedge clk_i);
        total++; if (cyc_o !== 1'b1) begin bad++; $display("FAIL rst_pre_cyc: got %b want 1", cyc_o); end
        #2 rst_i = 1;
        #1;
        total++; if ({cyc_o, stb_o} !== 2'b00) begin bad++; $display("FAIL rst_async_drop: got %b want 00", {cyc_o, stb_o}); end
        psel = 0; penable = 0;
        @(negedge clk_i);
        rst_i = 0;
        ack_i = 1; dat_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        ack_i = 0;
        total++; if ({cyc_o, pready, prdata} !== 34'h0) begin
            bad++; $display("FAIL rst_late_ack: got cyc=%b rdy=%b rd=%h want 0 0 0", cyc_o, pready, prdata); end
        xfer(32'h8000_0044, 0, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, o);
        bus_idle();
        total++; if ({o.k, o.err, o.rdata, o.adr} !== {32'd4, 1'b0, 32'h0BAD_CAFE, 32'h44}) begin
            bad++; $display("FAIL rst_recover: got k=%0d err=%b rd=%h adr=%h want 4 0 0badcafe 44", o.k, o.err, o.rdata, o.adr); end
    endtask

    task automatic test_back_to_back();
        obs_t a, b;
        xfer(32'h8000_0200, 1, 32'h0102_0304, 4'hF, 0, 32'h0, a);
        xfer(32'h8000_0203, 0, 32'h0, 4'h0, 0, 32'h5A5A_A5A5, b);
        bus_idle();
        total++; if ({a.k, a.err} !== {32'd2, 1'b0}) begin bad++; $display("FAIL b2b_first: got k=%0d err=%b want 2 0", a.k, a.err); end
        total++; if ({b.pready_before, b.k, b.rdata, b.adr} !== {1'b0, 32'd2, 32'h5A5A_A5A5, 32'h200}) begin
            bad++; $display("FAIL b2b_second: got rdy0=%b k=%0d rd=%h adr=%h want 0 2 5a5aa5a5 200", b.pready_before, b.k, b.rdata, b.adr); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] r, addr, wdata, rdata;
        logic        wr, exp_wb, exp_err;
        logic [3:0]  strb;
        int          d;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            if ($urandom_range(3) != 0) addr = {8'h80, r[23:0]};
            else begin
                addr = r;
                if (addr[31:24] == 8'h80) addr[31:24] = 8'h81;
            end
            wr    = 1'($urandom_range(1));
            strb  = 4'($urandom_range(15));
            wdata = $urandom();
            rdata = $urandom();
            d     = $urandom_range(3);
            model(addr, wr, strb, exp_wb, exp_err);
            xfer(addr, wr, wdata, strb, d, rdata, o);
            if ($urandom_range(1) == 1) bus_idle();
            total++;
            if ({o.k, o.err, o.wb_cycles, o.pready_before} !== {32'(exp_wb ? d + 2 : 1), exp_err, 32'(exp_wb), 1'b0}) begin
                bad++; $display("FAIL rnd%0d_resp: got k=%0d err=%b cyc=%0d rdy0=%b want k=%0d err=%b cyc=%0d rdy0=0",
                                i, o.k, o.err, o.wb_cycles, o.pready_before, exp_wb ? d + 2 : 1, exp_err, exp_wb);
            end
            if (exp_wb) begin
                total++;
                if ({o.adr, o.sel, o.we, o.unstable, o.cyc_at_ready} !==
                    {wr ? {8'h0, addr[23:0]} : {8'h0, addr[23:2], 2'b00}, wr ? strb : 4'hF, wr, 1'b0, 1'b0}) begin
                    bad++; $display("FAIL rnd%0d_wb: got adr=%h sel=%h we=%b unst=%b cyc=%b for addr=%h wr=%b strb=%h",
                                    i, o.adr, o.sel, o.we, o.unstable, o.cyc_at_ready, addr, wr, strb);
                end
                if (wr) begin
                    total++;
                    if (o.dat !== wdata) begin bad++; $display("FAIL rnd%0d_wdat: got %h want %h", i, o.dat, wdata); end
                end
            end
            if (!wr) begin
                total++;
                if (o.rdata !== (exp_wb ? rdata : 32'h0)) begin
                    bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o.rdata, exp_wb ? rdata : 32'h0);
                end
            end
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_strobe_screen();
        test_out_of_window();
        test_timeout();
        test_reset_in_req();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
